timer_ctc: RTL and testbench

TIMER_CTC -- requirements
Module: timer_ctc

---
 rtl/ctc_pkg.sv | 23 ++
 rtl/ctc_if.sv | 21 ++
 rtl/ctc_channel.sv | 111 +++++++++++
 rtl/timer_ctc.sv | 45 ++++
 tb/tb_timer_ctc.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctc_pkg.sv
// ctc_pkg: shared register map, ctrl/status bit positions and status packing for timer_ctc
package ctc_pkg;

    typedef enum logic [1:0] {
        CTC_CTRL0 = 2'b00,
        CTC_CTRL1 = 2'b01,
        CTC_VAL0  = 2'b10,
        CTC_VAL1  = 2'b11
    } ctc_reg_e;

    localparam int MODE_BIT   = 0;
    localparam int REPEAT_BIT = 1;
    localparam int DONE_BIT   = 0;
    localparam int RUN_BIT    = 15;

    // Builds the ctrl/status read word from a channel's running and done flags.
    function automatic logic [15:0] status_word(input logic run, input logic done);
        status_word = '0;
        status_word[RUN_BIT] = run;
        status_word[DONE_BIT] = done;
    endfunction

endpackage

// File: rtl/ctc_if.sv
// ctc_if: CPU-side IO bus of the counter/timer block (chip select, strobes, index, data)
interface ctc_if;

    logic        ctccs;
    logic        ctcwrite;
    logic        ctcread;
    logic [1:0]  ctcaddr;
    logic [15:0] ctcwdata;
    logic [15:0] ctcrdata;

    modport master (
        output ctccs, ctcwrite, ctcread, ctcaddr, ctcwdata,
        input  ctcrdata
    );

    modport slave (
        input  ctccs, ctcwrite, ctcread, ctcaddr, ctcwdata,
        output ctcrdata
    );

endinterface

// File: rtl/ctc_channel.sv
// ctc_channel: one timer/counter channel; expiry pulse registers exist only with CTC_PULSE_OUT_EN
module ctc_channel
    import ctc_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic        clock,
    input  logic        prst,
    input  logic        wr_ctrl_i,
    input  logic        wr_val_i,
    input  logic        rd_ctrl_i,
    input  logic [15:0] wdata_i,
    input  logic        pulse_i,
    output logic [15:0] status_o,
    output logic [15:0] value_o,
    output logic        pulse_n_o
);

    logic                 mode_q, mode_d;
    logic                 rpt_q, rpt_d;
    logic                 run_q, run_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] init_q, init_d;
    logic [CNT_WIDTH-1:0] cur_q, cur_d;
    logic [2:0]           sync_q;
    logic [CNT_WIDTH-1:0] wval;
    logic                 tick;
    logic                 expire;

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] remembers the previous synchronized level
    assign wval   = wdata_i[CNT_WIDTH-1:0];
    assign tick   = mode_q ? (sync_q[1] & ~sync_q[2]) : 1'b1;
    assign expire = run_q & tick & (cur_q == CNT_WIDTH'(1)) & ~wr_ctrl_i & ~wr_val_i;

    // Next state: ctrl write stops the channel, value write (re)arms it, otherwise count/expire
    always_comb begin
        mode_d = mode_q;
        rpt_d  = rpt_q;
        run_d  = run_q;
        done_d = done_q;
        init_d = init_q;
        cur_d  = cur_q;
        if (wr_ctrl_i) begin
            mode_d = wdata_i[MODE_BIT];
            rpt_d  = wdata_i[REPEAT_BIT];
            run_d  = 1'b0;
            done_d = 1'b0;
        end else if (wr_val_i) begin
            init_d = wval;
            cur_d  = wval;
            run_d  = |wval;
        end else begin
            if (expire) begin
                cur_d = rpt_q ? init_q : '0;
                run_d = rpt_q;
            end else if (run_q && tick && cur_q != '0) begin
                cur_d = cur_q - CNT_WIDTH'(1);
            end
            done_d = expire | (done_q & ~rd_ctrl_i);
        end
    end

    // Channel state registers
    always_ff @(posedge clock or negedge prst) begin
        if (!prst) begin
            mode_q <= 1'b0;
            rpt_q  <= 1'b0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            init_q <= '0;
            cur_q  <= '0;
        end else begin
            mode_q <= mode_d;
            rpt_q  <= rpt_d;
            run_q  <= run_d;
            done_q <= done_d;
            init_q <= init_d;
            cur_q  <= cur_d;
        end
    end

    // Synchronizer and edge register for the external event input
    always_ff @(posedge clock or negedge prst) begin
        if (!prst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], pulse_i};
        end
    end

`ifdef CTC_PULSE_OUT_EN
    logic pulse_n_q;

    // Active-low expiry pulse, one clock wide, in the cycle after the expiry edge
    always_ff @(posedge clock or negedge prst) begin
        if (!prst) begin
            pulse_n_q <= 1'b1;
        end else begin
            pulse_n_q <= ~expire;
        end
    end

    assign pulse_n_o = pulse_n_q;
`else
    assign pulse_n_o = 1'b1;
`endif

    assign status_o = status_word(run_q, done_q);
    assign value_o  = 16'(cur_q);

endmodule

// File: rtl/timer_ctc.sv
// timer_ctc: two-channel counter/timer on the CPU IO bus; define CTC_PULSE_OUT_EN for expiry pulses
module timer_ctc
    import ctc_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic       clock,
    input  logic       prst,
    ctc_if.slave       bus,
    input  logic [1:0] pulse_in,
    output logic [1:0] pulse_out
);

    logic        wr;
    logic        rd;
    logic [15:0] status [2];
    logic [15:0] value  [2];

    // A simultaneous read and write strobe is treated as a write only
    assign wr = bus.ctccs & bus.ctcwrite;
    assign rd = bus.ctccs & bus.ctcread & ~bus.ctcwrite;

    for (genvar c = 0; c < 2; c++) begin : g_ch
        ctc_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clock    (clock),
            .prst     (prst),
            .wr_ctrl_i(wr && bus.ctcaddr == (c == 0 ? CTC_CTRL0 : CTC_CTRL1)),
            .wr_val_i (wr && bus.ctcaddr == (c == 0 ? CTC_VAL0 : CTC_VAL1)),
            .rd_ctrl_i(rd && bus.ctcaddr == (c == 0 ? CTC_CTRL0 : CTC_CTRL1)),
            .wdata_i  (bus.ctcwdata),
            .pulse_i  (pulse_in[c]),
            .status_o (status[c]),
            .value_o  (value[c]),
            .pulse_n_o(pulse_out[c])
        );
    end

    // Combinational read mux, forced to zero while reset is asserted or when not selected
    always_comb begin
        bus.ctcrdata = (prst && rd) ? (bus.ctcaddr[1] ? value[bus.ctcaddr[0]] : status[bus.ctcaddr[0]]) : '0;
    end

endmodule

// File: tb/tb_timer_ctc.sv
// tb_timer_ctc: self-checking bench for timer_ctc against a behavioural channel model
module tb_timer_ctc;

    logic       clock = 1'b0;
    logic       prst = 1'b1;
    logic [1:0] pulse_in = 2'b00;
    logic [1:0] pulse_out;
    int         n_pass = 0;
    int         n_total = 0;

    bit         m_mode [2];
    bit         m_rpt  [2];
    bit         m_run  [2];
    bit         m_done [2];
    int         m_init [2];
    int         m_cur  [2];
    logic [2:0] m_hist [2];
    logic [1:0] m_pout;

    ctc_if bus();

    timer_ctc #(.CNT_WIDTH(16)) dut (
        .clock    (clock),
        .prst     (prst),
        .bus      (bus),
        .pulse_in (pulse_in),
        .pulse_out(pulse_out)
    );

    always #5 clock = ~clock;

    task automatic set_bus(input logic cs, input logic w, input logic r, input logic [1:0] a, input logic [15:0] d);
        bus.ctccs = cs;
        bus.ctcwrite = w;
        bus.ctcread = r;
        bus.ctcaddr = a;
        bus.ctcwdata = d;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_mode[c] = 0; m_rpt[c] = 0; m_run[c] = 0; m_done[c] = 0;
            m_init[c] = 0; m_cur[c] = 0; m_hist[c] = '0;
        end
        m_pout = 2'b11;
    endtask

    // m_hist[c][k] holds pulse_in as seen k+1 edges ago; a rise three edges back decrements now
    task automatic model_edge();
        bit w, r, rise, ex;
        w = bus.ctccs && bus.ctcwrite;
        r = bus.ctccs && bus.ctcread && !bus.ctcwrite;
        for (int c = 0; c < 2; c++) begin
            rise = m_hist[c][1] && !m_hist[c][2];
            m_hist[c] = {m_hist[c][1:0], pulse_in[c]};
            ex = 0;
            if (w && bus.ctcaddr == 2'(c)) begin
                m_mode[c] = bus.ctcwdata[0]; m_rpt[c] = bus.ctcwdata[1];
                m_run[c] = 0; m_done[c] = 0;
            end else if (w && bus.ctcaddr == 2'(c + 2)) begin
                m_init[c] = int'(bus.ctcwdata); m_cur[c] = int'(bus.ctcwdata);
                m_run[c] = bus.ctcwdata != 0;
            end else begin
                if (m_run[c] && (m_mode[c] ? rise : 1'b1)) begin
                    if (m_cur[c] == 1) begin
                        ex = 1; m_done[c] = 1;
                        m_cur[c] = m_rpt[c] ? m_init[c] : 0;
                        m_run[c] = m_rpt[c];
                    end else if (m_cur[c] > 0) begin
                        m_cur[c] = m_cur[c] - 1;
                    end
                end
                if (r && bus.ctcaddr == 2'(c) && !ex) m_done[c] = 0;
            end
`ifdef CTC_PULSE_OUT_EN
            m_pout[c] = !ex;
`else
            m_pout[c] = 1'b1;
`endif
        end
    endtask

    function automatic logic [15:0] exp_rdata();
        logic [1:0] a;
        a = bus.ctcaddr;
        if (!prst || !(bus.ctccs && bus.ctcread && !bus.ctcwrite)) return 16'h0000;
        if (!a[1]) return {m_run[a[0]], 14'b0, m_done[a[0]]};
        return 16'(m_cur[a[0]]);
    endfunction

    task automatic step();
        @(posedge clock);
        if (prst) model_edge();
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
        set_bus(1, 1, 0, a, d);
        step();
        set_bus(0, 0, 0, 2'd0, 16'h0);
    endtask

    task automatic test_reset();
        #2 prst = 1'b0;
        model_reset();
        set_bus(1, 0, 1, 2'd2, 16'h0);
        #1;
        n_total++; if (bus.ctcrdata !== 16'h0000) $display("FAIL rst_rdata: got %h want 0000", bus.ctcrdata); else n_pass++;
        n_total++; if (pulse_out !== 2'b11) $display("FAIL rst_pout: got %b want 11", pulse_out); else n_pass++;
        step();
        step();
        prst = 1'b1;
        for (int a = 0; a < 4; a++) begin
            set_bus(1, 0, 1, 2'(a), 16'h0);
            #1;
            n_total++; if (bus.ctcrdata !== 16'h0000) $display("FAIL rst_reg%0d: got %h want 0000", a, bus.ctcrdata); else n_pass++;
            step();
        end
        set_bus(0, 0, 0, 2'd0, 16'h0);
    endtask

    task automatic test_timer_oneshot();
        int seq [7] = '{5, 4, 3, 2, 1, 0, 0};
        wr_reg(2'd0, 16'h0000);
        wr_reg(2'd2, 16'd5);
        for (int i = 0; i < 7; i++) begin
            set_bus(1, 0, 1, 2'd2, 16'h0);
            #1;
            n_total++; if (bus.ctcrdata !== 16'(seq[i])) $display("FAIL oneshot_cur%0d: got %0d want %0d", i, bus.ctcrdata, seq[i]); else n_pass++;
            n_total++; if (pulse_out !== m_pout) $display("FAIL oneshot_pout%0d: got %b want %b", i, pulse_out, m_pout); else n_pass++;
            step();
        end
        set_bus(1, 0, 1, 2'd0, 16'h0);
        #1;
        n_total++; if (bus.ctcrdata !== 16'h0001) $display("FAIL oneshot_status: got %h want 0001", bus.ctcrdata); else n_pass++;
        step();
        #1;
        n_total++; if (bus.ctcrdata !== 16'h0000) $display("FAIL oneshot_status_clr: got %h want 0000", bus.ctcrdata); else n_pass++;
        set_bus(0, 0, 0, 2'd0, 16'h0);
    endtask

    task automatic test_timer_repeat();
        int lows = 0;
        int mlows = 0;
        wr_reg(2'd1, 16'h0002);
        wr_reg(2'd3, 16'd3);
        for (int i = 0; i < 10; i++) begin
            set_bus(1, 0, 1, 2'd3, 16'h0);
            #1;
            n_total++; if (bus.ctcrdata !== 16'(3 - (i % 3))) $display("FAIL repeat_cur%0d: got %0d want %0d", i, bus.ctcrdata, 3 - (i % 3)); else n_pass++;
            if (!pulse_out[1]) lows++;
            if (!m_pout[1]) mlows++;
            step();
        end
        n_total++; if (lows !== mlows) $display("FAIL repeat_pulses: got %0d want %0d", lows, mlows); else n_pass++;
        set_bus(1, 0, 1, 2'd1, 16'h0);
        #1;
        n_total++; if (bus.ctcrdata !== 16'h8001) $display("FAIL repeat_status: got %h want 8001", bus.ctcrdata); else n_pass++;
        step();
        wr_reg(2'd1, 16'h0000);
    endtask

    task automatic test_counter();
        int first_done = -1;
        wr_reg(2'd0, 16'h0001);
        wr_reg(2'd2, 16'd2);
        for (int i = 0; i < 24; i++) begin
            pulse_in[0] = (i >= 2 && i < 8) || (i >= 12 && i < 18);
            set_bus(1, 0, 1, 2'd0, 16'h0);
            #1;
            n_total++; if (bus.ctcrdata !== exp_rdata()) $display("FAIL counter_status%0d: got %h want %h", i, bus.ctcrdata, exp_rdata()); else n_pass++;
            if (bus.ctcrdata[0] && first_done < 0) first_done = i;
            step();
        end
        n_total++; if (first_done !== 15) $display("FAIL counter_done_cycle: got %0d want 15", first_done); else n_pass++;
        pulse_in[0] = 1'b0;
        set_bus(1, 0, 1, 2'd2, 16'h0);
        #1;
        n_total++; if (bus.ctcrdata !== 16'h0000) $display("FAIL counter_cur: got %h want 0000", bus.ctcrdata); else n_pass++;
        step();
        wr_reg(2'd0, 16'h0000);
    endtask

    task automatic test_read_race();
        logic [15:0] seq [6] = '{16'h8000, 16'h8000, 16'h8000, 16'h0001, 16'h0000, 16'h0000};
        wr_reg(2'd2, 16'd3);
        for (int i = 0; i < 6; i++) begin
            set_bus(1, 0, 1, 2'd0, 16'h0);
            #1;
            n_total++; if (bus.ctcrdata !== seq[i]) $display("FAIL race_status%0d: got %h want %h", i, bus.ctcrdata, seq[i]); else n_pass++;
            step();
        end
        set_bus(0, 0, 0, 2'd0, 16'h0);
    endtask

    task automatic test_reset_midcount();
        int lows = 0;
        int bad = 0;
        wr_reg(2'd2, 16'd100);
        repeat (10) step();
        #3 prst = 1'b0;
        model_reset();
        set_bus(1, 0, 1, 2'd2, 16'h0);
        #1;
        n_total++; if (bus.ctcrdata !== 16'h0000) $display("FAIL midrst_rdata: got %h want 0000", bus.ctcrdata); else n_pass++;
        n_total++; if (pulse_out !== 2'b11) $display("FAIL midrst_pout: got %b want 11", pulse_out); else n_pass++;
        step();
        prst = 1'b1;
        for (int i = 0; i < 110; i++) begin
            set_bus(1, 0, 1, 2'd2, 16'h0);
            #1;
            if (bus.ctcrdata !== 16'h0000) bad++;
            if (pulse_out !== 2'b11) lows++;
            step();
        end
        n_total++; if (bad !== 0) $display("FAIL midrst_cur: got %0d nonzero reads want 0", bad); else n_pass++;
        n_total++; if (lows !== 0) $display("FAIL midrst_pulse: got %0d pulses want 0", lows); else n_pass++;
        set_bus(1, 0, 1, 2'd0, 16'h0);
        #1;
        n_total++; if (bus.ctcrdata !== 16'h0000) $display("FAIL midrst_status: got %h want 0000", bus.ctcrdata); else n_pass++;
        step();
        set_bus(0, 0, 0, 2'd0, 16'h0);
    endtask

    task automatic test_zero_and_precedence();
        int lows = 0;
        wr_reg(2'd2, 16'd0);
        for (int i = 0; i < 4; i++) begin
            set_bus(1, 0, 1, 2'd0, 16'h0);
            #1;
            if (i == 0) begin
                n_total++; if (bus.ctcrdata !== 16'h0000) $display("FAIL zero_status: got %h want 0000", bus.ctcrdata); else n_pass++;
            end
            if (pulse_out !== 2'b11) lows++;
            step();
        end
        n_total++; if (lows !== 0) $display("FAIL zero_pulse: got %0d pulses want 0", lows); else n_pass++;
        wr_reg(2'd1, 16'h0000);
        wr_reg(2'd3, 16'd2);
        step();
        wr_reg(2'd3, 16'd7);
        n_total++; if (pulse_out !== 2'b11) $display("FAIL prec_pout: got %b want 11", pulse_out); else n_pass++;
        set_bus(1, 0, 1, 2'd3, 16'h0);
        #1;
        n_total++; if (bus.ctcrdata !== 16'd7) $display("FAIL prec_cur: got %0d want 7", bus.ctcrdata); else n_pass++;
        step();
        set_bus(1, 0, 1, 2'd1, 16'h0);
        #1;
        n_total++; if (bus.ctcrdata !== 16'h8000) $display("FAIL prec_status: got %h want 8000", bus.ctcrdata); else n_pass++;
        step();
        wr_reg(2'd1, 16'h0000);
    endtask

    task automatic test_random();
        int op;
        logic [1:0] a;
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 99));
            a = 2'($urandom_range(0, 3));
            if (op < 8) set_bus(1, 1, 0, a, a[1] ? 16'($urandom_range(0, 5)) : 16'($urandom_range(0, 3)));
            else if (op < 11) set_bus(0, 1, 0, a, 16'($urandom_range(0, 5)));
            else if (op < 13) set_bus(1, 1, 1, a, 16'($urandom_range(0, 3)));
            else if (op < 60) set_bus(1, 0, 1, a, 16'h0);
            else set_bus(0, 0, 0, a, 16'h0);
            for (int c = 0; c < 2; c++) if ($urandom_range(0, 3) == 0) pulse_in[c] = ~pulse_in[c];
            #1;
            n_total++; if (bus.ctcrdata !== exp_rdata()) $display("FAIL rand_rdata%0d: got %h want %h", i, bus.ctcrdata, exp_rdata()); else n_pass++;
            n_total++; if (pulse_out !== m_pout) $display("FAIL rand_pout%0d: got %b want %b", i, pulse_out, m_pout); else n_pass++;
            step();
        end
        set_bus(0, 0, 0, 2'd0, 16'h0);
    endtask

    initial begin
        set_bus(0, 0, 0, 2'd0, 16'h0);
        model_reset();
        test_reset();
        test_timer_oneshot();
        test_timer_repeat();
        test_counter();
        test_read_race();
        test_reset_midcount();
        test_zero_and_precedence();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
